// File: rtl/csr_trap_sequencer.sv
// Sequencer that owns the CSR file's single read address and write port.
// It runs CSR read-modify-write ops, trap entry and mret; arbitration priority is trap > mret > CSR op.
module csr_trap_sequencer #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [11:0] ADDR_MTVAL   = 12'h343,
  parameter bit          VECTORED     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_ack,
  output logic        csr_done,
  output logic [31:0] csr_result,
  output logic        csr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  output logic        trap_ack,
  input  logic        mret_valid,
  output logic        mret_ack,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_C_RD, S_C_WR,
    S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_STRD, S_T_STWR, S_T_JUMP,
    S_M_RD, S_M_WR, S_M_JUMP
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, old_q, result_q, cause_q, pc_q, tval_q;

  logic        idle, grant_trap, grant_mret, grant_csr;
  logic        write_req, read_only;
  logic [31:0] csr_new, trap_status, mret_status, trap_target;

  // Acks are combinational so the grant lands in the same IDLE cycle the request is seen.
  assign idle       = (state == S_IDLE) && !reset;
  assign grant_trap = idle && trap_valid;
  assign grant_mret = idle && mret_valid && !trap_valid;
  assign grant_csr  = idle && csr_valid && !trap_valid && !mret_valid;

  assign trap_ack   = grant_trap;
  assign mret_ack   = grant_mret;
  assign csr_ack    = grant_csr;
  assign busy       = (state != S_IDLE);
  assign csr_result = result_q;

  assign write_req  = (op_q == 2'b01) || (wdata_q != 32'h0);
  assign read_only  = (addr_q[11:10] == 2'b11);

  always_comb begin
    case (op_q)
      2'b01:   csr_new = wdata_q;
      2'b11:   csr_new = old_q & ~wdata_q;
      default: csr_new = old_q | wdata_q;
    endcase

    trap_status        = old_q;
    trap_status[7]     = old_q[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;

    mret_status        = old_q;
    mret_status[3]     = old_q[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b11;

    // Interrupts in vectored mode land at base + 4*code; wraps mod 2^32.
    trap_target = {csr_rdata[31:2], 2'b00};
    if (VECTORED && csr_rdata[1:0] == 2'b01 && cause_q[31])
      trap_target = trap_target + {cause_q[29:0], 2'b00};
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred on unlisted states.
    csr_we         = 1'b0;
    csr_waddr      = 12'h0;
    csr_wdata_o    = 32'h0;
    csr_raddr      = 12'h0;
    csr_done       = 1'b0;
    csr_illegal    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if (!reset) begin
      case (state)
        S_C_RD:    csr_raddr = addr_q;
        S_C_WR: begin
          csr_raddr   = addr_q;
          csr_done    = 1'b1;
          csr_illegal = write_req && read_only;
          csr_we      = write_req && !read_only;
          csr_waddr   = addr_q;
          csr_wdata_o = csr_new;
        end
        S_T_EPC:   begin csr_we = 1'b1; csr_waddr = ADDR_MEPC;    csr_wdata_o = pc_q;        end
        S_T_CAUSE: begin csr_we = 1'b1; csr_waddr = ADDR_MCAUSE;  csr_wdata_o = cause_q;     end
        S_T_TVAL:  begin csr_we = 1'b1; csr_waddr = ADDR_MTVAL;   csr_wdata_o = tval_q;      end
        S_T_STRD:  csr_raddr = ADDR_MSTATUS;
        S_T_STWR:  begin csr_we = 1'b1; csr_waddr = ADDR_MSTATUS; csr_wdata_o = trap_status; end
        S_T_JUMP: begin
          csr_raddr      = ADDR_MTVEC;
          redirect_valid = 1'b1;
          redirect_pc    = trap_target;
        end
        S_M_RD:    csr_raddr = ADDR_MSTATUS;
        S_M_WR:    begin csr_we = 1'b1; csr_waddr = ADDR_MSTATUS; csr_wdata_o = mret_status; end
        S_M_JUMP: begin
          csr_raddr      = ADDR_MEPC;
          redirect_valid = 1'b1;
          redirect_pc    = {csr_rdata[31:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_trap)      state <= S_T_EPC;
          else if (grant_mret) state <= S_M_RD;
          else if (grant_csr)  state <= S_C_RD;
        end
        S_C_RD: begin
          result_q <= csr_rdata;
          state    <= S_C_WR;
        end
        S_T_EPC:   state <= S_T_CAUSE;
        S_T_CAUSE: state <= S_T_TVAL;
        S_T_TVAL:  state <= S_T_STRD;
        S_T_STRD:  state <= S_T_STWR;
        S_T_STWR:  state <= S_T_JUMP;
        S_M_RD:    state <= S_M_WR;
        S_M_WR:    state <= S_M_JUMP;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are only read after an ack has loaded them.
  always_ff @(posedge clk) begin
    if (grant_trap) begin
      cause_q <= trap_cause;
      pc_q    <= trap_pc;
      tval_q  <= trap_tval;
    end
    if (grant_csr) begin
      op_q    <= csr_op;
      addr_q  <= csr_addr;
      wdata_q <= csr_wdata;
    end
    if (state == S_C_RD || state == S_T_STRD || state == S_M_RD)
      old_q <= csr_rdata;
  end

endmodule
